// File: rtl/id_ex_ctrl_pipe.sv
// ID/EX control pipeline: decodes the ID opcode into the extended control set,
// registers it into ID/EX, and handles load-use stalls, flushes and stall counting.
module id_ex_ctrl_pipe #(
  parameter int REG_AW           = 5,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int PERF_W           = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_branch_taken,
  output logic              ex_alusrc,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_regwrite,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic [1:0]        ex_aluop,
  output logic [1:0]        ex_wbsel,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_illegal,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef struct packed {
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       branch;
    logic       jump;
    logic [1:0] aluop;
    logic [1:0] wbsel;
  } ctrl_t;

  typedef enum logic {RUN, STALL} state_t;

  ctrl_t             dec, ex_q;
  logic              legal, uses_rs1, uses_rs2;
  logic              hazard, stall, flush;
  state_t            state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic [REG_AW-1:0] rd_q;
  logic              ill_q;
  logic [PERF_W-1:0] stall_q;

  always_comb begin
    dec      = '0;
    legal    = 1'b1;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (id_opcode)
      OP_R:    begin dec.regwrite = 1'b1; dec.aluop = 2'b10; uses_rs2 = 1'b1; end
      OP_I:    begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b10; end
      OP_LW:   begin dec.alusrc = 1'b1; dec.memread = 1'b1; dec.regwrite = 1'b1; dec.wbsel = 2'b01; end
      OP_SW:   begin dec.alusrc = 1'b1; dec.memwrite = 1'b1; uses_rs2 = 1'b1; end
      OP_BR:   begin dec.branch = 1'b1; dec.aluop = 2'b01; uses_rs2 = 1'b1; end
      OP_LUI:  begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b11; uses_rs1 = 1'b0; end
      OP_JAL:  begin dec.jump = 1'b1; dec.regwrite = 1'b1; dec.wbsel = 2'b10; uses_rs1 = 1'b0; end
      OP_JALR: begin dec.jump = 1'b1; dec.regwrite = 1'b1; dec.wbsel = 2'b10; dec.alusrc = 1'b1; end
      default: begin legal = 1'b0; uses_rs1 = 1'b0; end
    endcase
  end

  assign flush  = ex_branch_taken;
  assign hazard = id_valid && ex_q.memread && (rd_q != '0) &&
                  ((uses_rs1 && (id_rs1 == rd_q)) || (uses_rs2 && (id_rs2 == rd_q)));

  // In STALL the bubble count alone holds the pipe; the hazard is not re-evaluated.
  always_comb begin
    stall     = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else begin
      case (state)
        RUN: if (hazard) begin
          stall = 1'b1;
          if (LOAD_USE_BUBBLES > 1) begin
            state_nxt = STALL;
            cnt_nxt   = 2'(LOAD_USE_BUBBLES - 1);
          end
        end
        STALL: begin
          stall   = 1'b1;
          cnt_nxt = cnt - 2'd1;
          if (cnt == 2'd1) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      rd_q  <= '0;
      ill_q <= 1'b0;
    end else if (flush || stall || !id_valid) begin
      ex_q  <= '0;
      rd_q  <= '0;
      ill_q <= 1'b0;
    end else begin
      ex_q  <= dec;
      rd_q  <= id_rd;
      ill_q <= !legal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                         stall_q <= '0;
    else if (stall && (stall_q != '1)) stall_q <= stall_q + PERF_W'(1);
  end

  assign ex_alusrc    = ex_q.alusrc;
  assign ex_memread   = ex_q.memread;
  assign ex_memwrite  = ex_q.memwrite;
  assign ex_regwrite  = ex_q.regwrite;
  assign ex_branch    = ex_q.branch;
  assign ex_jump      = ex_q.jump;
  assign ex_aluop     = ex_q.aluop;
  assign ex_wbsel     = ex_q.wbsel;
  assign ex_rd        = rd_q;
  assign ex_illegal   = ill_q;
  assign pc_write     = !stall;
  assign ifid_write   = !stall;
  assign ifid_flush   = flush;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Directed bench: three instances (1 bubble, 3 bubbles, 1 bubble with 2-bit counter)
// share one stimulus stream; each phase checks the instance it targets.
module tb_id_ex_ctrl_pipe;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, LUI = 7'b0110111, JAL = 7'b1101111, JALR = 7'b1100111;

  logic clk = 1'b0, reset = 1'b1, id_valid = 1'b0, ex_branch_taken = 1'b0;
  logic [6:0] id_opcode = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [2:0] alusrc, memread, memwrite, regwrite, branch, jump, illegal;
  logic [2:0] pc_write, ifid_write, ifid_flush;
  logic [2:0][1:0] aluop, wbsel;
  logic [2:0][4:0] rd;
  logic [15:0] sc0, sc1;
  logic [1:0]  sc2;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  id_ex_ctrl_pipe #(.REG_AW(5), .LOAD_USE_BUBBLES(1), .PERF_W(16)) u_b1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .ex_alusrc(alusrc[0]), .ex_memread(memread[0]), .ex_memwrite(memwrite[0]),
    .ex_regwrite(regwrite[0]), .ex_branch(branch[0]), .ex_jump(jump[0]), .ex_aluop(aluop[0]),
    .ex_wbsel(wbsel[0]), .ex_rd(rd[0]), .ex_illegal(illegal[0]), .pc_write(pc_write[0]),
    .ifid_write(ifid_write[0]), .ifid_flush(ifid_flush[0]), .stall_cycles(sc0));

  id_ex_ctrl_pipe #(.REG_AW(5), .LOAD_USE_BUBBLES(3), .PERF_W(16)) u_b3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .ex_alusrc(alusrc[1]), .ex_memread(memread[1]), .ex_memwrite(memwrite[1]),
    .ex_regwrite(regwrite[1]), .ex_branch(branch[1]), .ex_jump(jump[1]), .ex_aluop(aluop[1]),
    .ex_wbsel(wbsel[1]), .ex_rd(rd[1]), .ex_illegal(illegal[1]), .pc_write(pc_write[1]),
    .ifid_write(ifid_write[1]), .ifid_flush(ifid_flush[1]), .stall_cycles(sc1));

  id_ex_ctrl_pipe #(.REG_AW(5), .LOAD_USE_BUBBLES(1), .PERF_W(2)) u_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .ex_alusrc(alusrc[2]), .ex_memread(memread[2]), .ex_memwrite(memwrite[2]),
    .ex_regwrite(regwrite[2]), .ex_branch(branch[2]), .ex_jump(jump[2]), .ex_aluop(aluop[2]),
    .ex_wbsel(wbsel[2]), .ex_rd(rd[2]), .ex_illegal(illegal[2]), .pc_write(pc_write[2]),
    .ifid_write(ifid_write[2]), .ifid_flush(ifid_flush[2]), .stall_cycles(sc2));

  // {alusrc,memread,memwrite,regwrite,branch,jump,aluop,wbsel}
  function automatic logic [9:0] ctl(input int i);
    return {alusrc[i], memread[i], memwrite[i], regwrite[i], branch[i], jump[i], aluop[i], wbsel[i]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic v, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] d);
    id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = d;
  endtask

  task automatic do_reset();
    reset = 1'b1; ins(1'b0, 7'd0, 5'd0, 5'd0, 5'd0); ex_branch_taken = 1'b0;
    tick(); reset = 1'b0;
  endtask

  initial begin
    // reset for two cycles
    tick();
    ex_branch_taken = 1'b1; #1;
    chk("rst_flush_follows", {29'd0, ifid_flush}, 32'h7);
    tick();
    ex_branch_taken = 1'b0; reset = 1'b0;
    tick();
    chk("rst_ctl", {22'd0, ctl(0)}, 32'h0);
    chk("rst_rd_ill", {rd[0], illegal[0]}, 32'h0);
    chk("rst_pcw", {30'd0, pc_write[0], ifid_write[0]}, 32'h3);
    chk("rst_flush", {31'd0, ifid_flush[0]}, 32'h0);
    chk("rst_sc", {16'd0, sc0}, 32'd0);

    // decode: LUI, JALR, I, BR
    ins(1'b1, LUI, 5'd0, 5'd0, 5'd3); tick();
    chk("lui_ctl", {22'd0, ctl(0)}, 32'b1001001100);
    chk("lui_rd", {27'd0, rd[0]}, 32'd3);
    ins(1'b1, JALR, 5'd3, 5'd0, 5'd1); tick();
    chk("jalr_ctl", {22'd0, ctl(0)}, 32'b1001010010);
    chk("jalr_rd", {27'd0, rd[0]}, 32'd1);
    ins(1'b1, I, 5'd2, 5'd0, 5'd4); tick();
    chk("i_ctl", {22'd0, ctl(0)}, 32'b1001001000);
    ins(1'b1, BR, 5'd1, 5'd2, 5'd0); tick();
    chk("br_ctl", {22'd0, ctl(0)}, 32'b0000100100);

    // load-use, one bubble
    ins(1'b1, LW, 5'd1, 5'd0, 5'd5); tick();
    chk("lw_ctl", {22'd0, ctl(0)}, 32'b1101000001);
    ins(1'b1, R, 5'd5, 5'd1, 5'd6); #1;
    chk("lu1_stall", {30'd0, pc_write[0], ifid_write[0]}, 32'h0);
    tick();
    chk("lu1_bubble", {17'd0, ctl(0), rd[0]}, 32'h0);
    chk("lu1_release", {31'd0, pc_write[0]}, 32'h1);
    tick();
    chk("lu1_add_ctl", {22'd0, ctl(0)}, 32'b0001001000);
    chk("lu1_add_rd", {27'd0, rd[0]}, 32'd6);
    chk("lu1_sc", {16'd0, sc0}, 32'd1);

    // no-stall: LW x0 then use of x0
    ins(1'b1, LW, 5'd1, 5'd0, 5'd0); tick();
    ins(1'b1, R, 5'd0, 5'd0, 5'd7); #1;
    chk("x0_nostall", {31'd0, pc_write[0]}, 32'h1);
    tick();
    chk("x0_add_rd", {27'd0, rd[0]}, 32'd7);
    // LW x5 then LUI x5 / JAL with x5 in the unused source fields
    ins(1'b1, LW, 5'd1, 5'd0, 5'd5); tick();
    ins(1'b1, LUI, 5'd5, 5'd5, 5'd5); #1;
    chk("lui_nostall", {31'd0, pc_write[0]}, 32'h1);
    tick();
    ins(1'b1, LW, 5'd1, 5'd0, 5'd5); tick();
    ins(1'b1, JAL, 5'd5, 5'd5, 5'd1); #1;
    chk("jal_nostall", {31'd0, pc_write[0]}, 32'h1);
    tick();
    chk("jal_ctl", {22'd0, ctl(0)}, 32'b0001010010);
    // SW depends on load through rs2
    ins(1'b1, LW, 5'd1, 5'd0, 5'd5); tick();
    ins(1'b1, SW, 5'd2, 5'd5, 5'd0); #1;
    chk("sw_rs2_stall", {31'd0, pc_write[0]}, 32'h0);
    tick(); tick();
    chk("sw_ctl", {22'd0, ctl(0)}, 32'b1010000000);
    chk("sw_sc", {16'd0, sc0}, 32'd2);
    // invalid slot does not stall even with matching fields
    ins(1'b1, LW, 5'd1, 5'd0, 5'd5); tick();
    ins(1'b0, R, 5'd5, 5'd5, 5'd6); #1;
    chk("inv_nostall", {31'd0, pc_write[0]}, 32'h1);
    tick();

    // illegal opcode
    ins(1'b1, 7'b1111111, 5'd1, 5'd2, 5'd3); tick();
    chk("ill_flag", {31'd0, illegal[0]}, 32'h1);
    chk("ill_ctl", {22'd0, ctl(0)}, 32'h0);
    ins(1'b0, 7'b1111111, 5'd1, 5'd2, 5'd3); tick();
    chk("ill_invalid", {31'd0, illegal[0]}, 32'h0);

    // three bubbles
    do_reset();
    ins(1'b1, LW, 5'd1, 5'd0, 5'd5); tick();
    ins(1'b1, R, 5'd5, 5'd1, 5'd6); #1;
    chk("lu3_c1", {31'd0, pc_write[1]}, 32'h0);
    tick();
    chk("lu3_c2_pcw", {31'd0, pc_write[1]}, 32'h0);
    chk("lu3_c2_bub", {22'd0, ctl(1)}, 32'h0);
    tick();
    chk("lu3_c3_pcw", {31'd0, pc_write[1]}, 32'h0);
    chk("lu3_c3_bub", {22'd0, ctl(1)}, 32'h0);
    tick();
    chk("lu3_c4_pcw", {31'd0, pc_write[1]}, 32'h1);
    chk("lu3_c4_bub", {22'd0, ctl(1)}, 32'h0);
    tick();
    chk("lu3_add", {17'd0, ctl(1), rd[1]}, {17'd0, 10'b0001001000, 5'd6});
    chk("lu3_sc", {16'd0, sc1}, 32'd3);

    // flush in second stall cycle
    do_reset();
    ins(1'b1, LW, 5'd1, 5'd0, 5'd5); tick();
    ins(1'b1, R, 5'd5, 5'd1, 5'd6); tick();
    ex_branch_taken = 1'b1; #1;
    chk("fl_pcw", {31'd0, pc_write[1]}, 32'h1);
    chk("fl_ifid_flush", {31'd0, ifid_flush[1]}, 32'h1);
    tick();
    ex_branch_taken = 1'b0; ins(1'b0, 7'd0, 5'd0, 5'd0, 5'd0); #1;
    chk("fl_bubble", {17'd0, ctl(1), rd[1]}, 32'h0);
    chk("fl_sc", {16'd0, sc1}, 32'd1);
    chk("fl_after_pcw", {31'd0, pc_write[1]}, 32'h1);

    // flush coincident with hazard
    ins(1'b1, LW, 5'd1, 5'd0, 5'd5); tick();
    ins(1'b1, R, 5'd5, 5'd1, 5'd6); ex_branch_taken = 1'b1; #1;
    chk("flhz_pcw", {31'd0, pc_write[1]}, 32'h1);
    tick();
    ex_branch_taken = 1'b0;
    chk("flhz_bubble", {22'd0, ctl(1)}, 32'h0);
    chk("flhz_sc", {16'd0, sc1}, 32'd1);

    // reset mid-stall
    ins(1'b1, LW, 5'd1, 5'd0, 5'd5); tick();
    ins(1'b1, R, 5'd5, 5'd1, 5'd6); tick();
    reset = 1'b1; tick();
    reset = 1'b0; ins(1'b0, 7'd0, 5'd0, 5'd0, 5'd0); #1;
    chk("rstmid_pcw", {31'd0, pc_write[1]}, 32'h1);
    chk("rstmid_sc", {16'd0, sc1}, 32'd0);
    tick();
    chk("rstmid_pcw2", {31'd0, pc_write[1]}, 32'h1);

    // saturation: five single-bubble hazards on a 2-bit counter
    do_reset();
    for (int k = 0; k < 5; k++) begin
      ins(1'b1, LW, 5'd1, 5'd0, 5'd5); tick();
      ins(1'b1, R, 5'd5, 5'd1, 5'd6); tick(); tick();
      if (k == 1) chk("sat_k1", {30'd0, sc2}, 32'd2);
      if (k == 2) chk("sat_k2", {30'd0, sc2}, 32'd3);
    end
    chk("sat_final", {30'd0, sc2}, 32'd3);
    chk("sat_wide", {16'd0, sc0}, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
